// File: rtl/axil_stream_bridge.sv
// AXI-lite slave that pushes DATA-register writes into a FIFO drained on a stream master port.
// Define AXIL_STREAM_BRIDGE_DROP_CNT_EN to build the saturating DROP counter register.
module axil_stream_bridge #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [31:0]           s_awaddr,
    input  logic                  s_awvalid,
    output logic                  s_awready,
    input  logic [DATA_WIDTH-1:0] s_wdata,
    input  logic                  s_wvalid,
    output logic                  s_wready,
    output logic                  s_bvalid,
    input  logic                  s_bready,
    output logic                  s_bresp,
    input  logic [31:0]           s_araddr,
    input  logic                  s_arvalid,
    output logic                  s_arready,
    output logic [DATA_WIDTH-1:0] s_rdata,
    output logic                  s_rvalid,
    input  logic                  s_rready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_DROP   = 2'd2;

    typedef enum logic {W_IDLE, W_RESP} w_state_e;
    typedef enum logic {R_IDLE, R_DATA} r_state_e;

    w_state_e w_state_q, w_state_d;
    r_state_e r_state_q, r_state_d;
    logic     bresp_q, bresp_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [DATA_WIDTH-1:0] rd_val;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic wr_accept;
    logic wr_is_data;
    logic fifo_full;
    logic fifo_empty;
    logic push;
    logic pop;
    logic drop_evt;
    logic [15:0] drop_cnt;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{s_awaddr[31:4], s_awaddr[1:0], s_araddr[31:4], s_araddr[1:0]};

    assign fifo_full  = (count_q == CW'(DEPTH));
    assign fifo_empty = (count_q == '0);
    assign wr_is_data = (s_awaddr[3:2] == ADDR_DATA);
    // Full is taken from the registered count, so a same-cycle pop cannot rescue a write.
    assign push       = wr_accept && wr_is_data && !fifo_full;
    assign drop_evt   = wr_accept && wr_is_data && fifo_full;
    assign pop        = m_valid && m_ready;

    // ---------------- write channel FSM ----------------
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_state_d = w_state_q;
        bresp_d   = bresp_q;
        wr_accept = 1'b0;
        unique case (w_state_q)
            W_IDLE: begin
                if (s_awvalid && s_wvalid) begin
                    wr_accept = 1'b1;
                    bresp_d   = wr_is_data && fifo_full;
                    w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (s_bready) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    assign s_awready = (w_state_q == W_IDLE);
    assign s_wready  = (w_state_q == W_IDLE);
    assign s_bvalid  = (w_state_q == W_RESP);
    assign s_bresp   = bresp_q;

    // ---------------- read channel FSM ----------------
    always_comb begin
        rd_val = '0;
        unique case (s_araddr[3:2])
            ADDR_STATUS: begin
                rd_val[0]    = fifo_empty;
                rd_val[1]    = fifo_full;
                rd_val[15:8] = 8'(count_q);
            end
            ADDR_DROP: rd_val[15:0] = drop_cnt;
            default:   rd_val = '0;
        endcase
    end

    always_comb begin
        r_state_d = r_state_q;
        rdata_d   = rdata_q;
        unique case (r_state_q)
            R_IDLE: begin
                if (s_arvalid) begin
                    rdata_d   = rd_val;
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (s_rready) begin
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    assign s_arready = (r_state_q == R_IDLE);
    assign s_rvalid  = (r_state_q == R_DATA);
    assign s_rdata   = rdata_q;

    // ---------------- FIFO ----------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    // NOTE: the storage array has no reset; only pointers and count qualify its contents.
    always_ff @(posedge aclk) begin
        if (push) begin
            mem[wr_ptr_q] <= s_wdata;
        end
    end

    assign m_data  = mem[rd_ptr_q];
    assign m_valid = !fifo_empty;

`ifdef AXIL_STREAM_BRIDGE_DROP_CNT_EN
    logic        drop_clr;
    logic [15:0] drop_cnt_q, drop_cnt_d;

    assign drop_clr = wr_accept && (s_awaddr[3:2] == ADDR_DROP);

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop_clr) begin
            drop_cnt_d = '0;
        end else if (drop_evt && drop_cnt_q != 16'hFFFF) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`else
    logic unused_drop_evt;
    assign unused_drop_evt = drop_evt;
    assign drop_cnt        = '0;
`endif

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_state_q <= W_IDLE;
            r_state_q <= R_IDLE;
            bresp_q   <= 1'b0;
            rdata_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
            bresp_q   <= bresp_d;
            rdata_q   <= rdata_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end

endmodule

// File: tb/tb_axil_stream_bridge.sv
// Directed self-checking bench for axil_stream_bridge (DATA_WIDTH 32, DEPTH 8).
// Expected DROP reads follow AXIL_STREAM_BRIDGE_DROP_CNT_EN when it is defined.
module tb_axil_stream_bridge;

    logic        aclk;
    logic        aresetn;
    logic [31:0] s_awaddr;
    logic        s_awvalid;
    logic        s_awready;
    logic [31:0] s_wdata;
    logic        s_wvalid;
    logic        s_wready;
    logic        s_bvalid;
    logic        s_bready;
    logic        s_bresp;
    logic [31:0] s_araddr;
    logic        s_arvalid;
    logic        s_arready;
    logic [31:0] s_rdata;
    logic        s_rvalid;
    logic        s_rready;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_ready;

    int checks = 0;
    int errors = 0;

`ifdef AXIL_STREAM_BRIDGE_DROP_CNT_EN
    localparam logic [31:0] EXP_DROP_ONE = 32'd1;
`else
    localparam logic [31:0] EXP_DROP_ONE = 32'd0;
`endif

    axil_stream_bridge #(.DATA_WIDTH(32), .DEPTH(8)) dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .s_awaddr  (s_awaddr),
        .s_awvalid (s_awvalid),
        .s_awready (s_awready),
        .s_wdata   (s_wdata),
        .s_wvalid  (s_wvalid),
        .s_wready  (s_wready),
        .s_bvalid  (s_bvalid),
        .s_bready  (s_bready),
        .s_bresp   (s_bresp),
        .s_araddr  (s_araddr),
        .s_arvalid (s_arvalid),
        .s_arready (s_arready),
        .s_rdata   (s_rdata),
        .s_rvalid  (s_rvalid),
        .s_rready  (s_rready),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    // Returns at the falling edge of the cycle after the accept (bvalid cycle).
    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic pop,
                             input logic brdy, output logic resp, output logic bv);
        int n;
        @(negedge aclk);
        s_awaddr = addr; s_awvalid = 1'b1; s_wdata = data; s_wvalid = 1'b1; s_bready = brdy;
        if (pop) m_ready = 1'b1;
        n = 0;
        while (!(s_awready && s_wready) && n < 20) begin
            @(negedge aclk);
            n++;
        end
        if (n == 20) begin
            errors++;
            $display("FAIL write_accept_timeout addr %h: got no accept, required accept", addr);
        end
        @(posedge aclk);
        #1;
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        if (pop) m_ready = 1'b0;
        @(negedge aclk);
        resp = s_bresp;
        bv   = s_bvalid;
    endtask

    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output logic rv);
        int n;
        @(negedge aclk);
        s_araddr = addr; s_arvalid = 1'b1; s_rready = 1'b1;
        n = 0;
        while (!s_arready && n < 20) begin
            @(negedge aclk);
            n++;
        end
        if (n == 20) begin
            errors++;
            $display("FAIL read_accept_timeout addr %h: got no accept, required accept", addr);
        end
        @(posedge aclk);
        #1;
        s_arvalid = 1'b0;
        @(negedge aclk);
        data = s_rdata;
        rv   = s_rvalid;
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        s_awaddr = '0; s_awvalid = 1'b0; s_wdata = '0; s_wvalid = 1'b0; s_bready = 1'b0;
        s_araddr = '0; s_arvalid = 1'b0; s_rready = 1'b0; m_ready = 1'b0;
        repeat (3) @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        checks++;
        if ({s_awready, s_wready, s_arready, s_bvalid, s_bresp, s_rvalid, m_valid} !== 7'b1110000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b required 1110000",
                     {s_awready, s_wready, s_arready, s_bvalid, s_bresp, s_rvalid, m_valid});
        end
        checks++;
        if (s_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_rdata: got %h required 00000000", s_rdata);
        end
    endtask

    task automatic test_single_write();
        logic resp, bv;
        m_ready = 1'b1;
        axi_write(32'h0, 32'hA5A5_0001, 1'b0, 1'b1, resp, bv);
        checks++;
        if ({bv, resp} !== 2'b10) begin
            errors++;
            $display("FAIL single_bresp: got bvalid/bresp %b required 10", {bv, resp});
        end
        checks++;
        if (m_valid !== 1'b1 || m_data !== 32'hA5A5_0001) begin
            errors++;
            $display("FAIL single_stream: got valid %b data %h required 1 a5a50001", m_valid, m_data);
        end
        @(negedge aclk);
        checks++;
        if (m_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_one_cycle: got m_valid %b required 0", m_valid);
        end
        m_ready = 1'b0;
    endtask

    task automatic test_fill_drop();
        logic        resp, bv;
        logic [8:0]  resps;
        logic [8:0]  bvs;
        logic [31:0] rd;
        logic        rv;
        m_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            axi_write(32'h0, 32'(i + 1), 1'b0, 1'b1, resp, bv);
            resps[i] = resp;
            bvs[i]   = bv;
        end
        checks++;
        if (resps !== 9'b1_0000_0000 || bvs !== 9'h1FF) begin
            errors++;
            $display("FAIL fill_bresp: got bresp %b bvalid %b required 100000000 111111111", resps, bvs);
        end
        axi_read(32'h4, rd, rv);
        checks++;
        if (rv !== 1'b1 || rd !== 32'h0000_0802) begin
            errors++;
            $display("FAIL fill_status: got rvalid %b data %h required 1 00000802", rv, rd);
        end
        axi_read(32'h8, rd, rv);
        checks++;
        if (rd !== EXP_DROP_ONE) begin
            errors++;
            $display("FAIL fill_drop_cnt: got %h required %h", rd, EXP_DROP_ONE);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (m_valid !== 1'b1 || m_data !== 32'(i + 1)) begin
                errors++;
                $display("FAIL drain_%0d: got valid %b data %h required 1 %h", i, m_valid, m_data, 32'(i + 1));
            end
            m_ready = 1'b1;
            @(negedge aclk);
        end
        m_ready = 1'b0;
        checks++;
        if (m_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain_empty: got m_valid %b required 0", m_valid);
        end
        axi_write(32'h8, 32'h0, 1'b0, 1'b1, resp, bv);
        axi_read(32'h8, rd, rv);
        checks++;
        if (resp !== 1'b0 || rd !== 32'h0) begin
            errors++;
            $display("FAIL drop_clear: got bresp %b drop %h required 0 00000000", resp, rd);
        end
    endtask

    task automatic test_full_with_pop();
        logic        resp, bv;
        logic [31:0] rd;
        logic        rv;
        for (int i = 0; i < 8; i++) begin
            axi_write(32'h0, 32'h10 + 32'(i), 1'b0, 1'b1, resp, bv);
        end
        axi_write(32'h0, 32'hDEAD, 1'b1, 1'b1, resp, bv);
        checks++;
        if ({bv, resp} !== 2'b11) begin
            errors++;
            $display("FAIL fullpop_bresp: got bvalid/bresp %b required 11", {bv, resp});
        end
        checks++;
        if (m_data !== 32'h11) begin
            errors++;
            $display("FAIL fullpop_head: got %h required 00000011", m_data);
        end
        axi_read(32'h4, rd, rv);
        checks++;
        if (rd !== 32'h0000_0700) begin
            errors++;
            $display("FAIL fullpop_status: got %h required 00000700", rd);
        end
        axi_read(32'h8, rd, rv);
        checks++;
        if (rd !== EXP_DROP_ONE) begin
            errors++;
            $display("FAIL fullpop_drop_cnt: got %h required %h", rd, EXP_DROP_ONE);
        end
        m_ready = 1'b1;
        repeat (7) @(negedge aclk);
        m_ready = 1'b0;
        checks++;
        if (m_valid !== 1'b0) begin
            errors++;
            $display("FAIL fullpop_drain: got m_valid %b required 0", m_valid);
        end
    endtask

    task automatic test_aw_before_w();
        logic        seen;
        logic [31:0] rd;
        logic        rv;
        @(negedge aclk);
        s_awaddr = 32'h0; s_awvalid = 1'b1; s_wvalid = 1'b0; s_wdata = 32'hCAFE; s_bready = 1'b1;
        seen = 1'b0;
        repeat (3) begin
            @(negedge aclk);
            seen = seen | s_bvalid | m_valid;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL awfirst_hold: got early accept %b required 0", seen);
        end
        s_wvalid = 1'b1;
        @(posedge aclk);
        #1;
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        @(negedge aclk);
        checks++;
        if ({s_bvalid, s_bresp} !== 2'b10) begin
            errors++;
            $display("FAIL awfirst_bresp: got bvalid/bresp %b required 10", {s_bvalid, s_bresp});
        end
        axi_read(32'h4, rd, rv);
        checks++;
        if (rd !== 32'h0000_0100 || m_data !== 32'hCAFE) begin
            errors++;
            $display("FAIL awfirst_push: got status %h head %h required 00000100 0000cafe", rd, m_data);
        end
    endtask

    task automatic test_concurrent_rw();
        logic [31:0] rd;
        logic        rv;
        @(negedge aclk);
        s_awaddr = 32'h0; s_awvalid = 1'b1; s_wdata = 32'hBEEF; s_wvalid = 1'b1; s_bready = 1'b1;
        s_araddr = 32'h4; s_arvalid = 1'b1; s_rready = 1'b1;
        @(posedge aclk);
        #1;
        s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
        @(negedge aclk);
        checks++;
        if ({s_bvalid, s_bresp, s_rvalid} !== 3'b101) begin
            errors++;
            $display("FAIL concurrent_valids: got bvalid/bresp/rvalid %b required 101", {s_bvalid, s_bresp, s_rvalid});
        end
        checks++;
        if (s_rdata !== 32'h0000_0100) begin
            errors++;
            $display("FAIL concurrent_status: got %h required 00000100", s_rdata);
        end
        axi_read(32'h4, rd, rv);
        checks++;
        if (rd !== 32'h0000_0200) begin
            errors++;
            $display("FAIL concurrent_after: got %h required 00000200", rd);
        end
    endtask

    task automatic test_regmap();
        logic        resp, bv;
        logic [31:0] rd;
        logic        rv;
        axi_read(32'h0, rd, rv);
        checks++;
        if (rv !== 1'b1 || rd !== 32'h0) begin
            errors++;
            $display("FAIL data_read: got rvalid %b data %h required 1 00000000", rv, rd);
        end
        axi_read(32'hC, rd, rv);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL rsvd_read: got %h required 00000000", rd);
        end
        axi_write(32'hC, 32'hFFFF_FFFF, 1'b0, 1'b1, resp, bv);
        axi_read(32'h4, rd, rv);
        checks++;
        if ({bv, resp} !== 2'b10 || rd !== 32'h0000_0200) begin
            errors++;
            $display("FAIL rsvd_write: got bvalid/bresp %b status %h required 10 00000200", {bv, resp}, rd);
        end
    endtask

    task automatic test_reset_midtx();
        logic        resp, bv;
        logic [31:0] rd;
        logic        rv;
        axi_write(32'h0, 32'h3, 1'b0, 1'b1, resp, bv);
        axi_write(32'h0, 32'h4, 1'b0, 1'b1, resp, bv);
        axi_write(32'hC, 32'h0, 1'b0, 1'b0, resp, bv);
        axi_read(32'h4, rd, rv);
        checks++;
        if (s_bvalid !== 1'b1 || rd !== 32'h0000_0400) begin
            errors++;
            $display("FAIL midtx_setup: got bvalid %b status %h required 1 00000400", s_bvalid, rd);
        end
        #2;
        aresetn = 1'b0;
        #1;
        checks++;
        if ({s_awready, s_wready, s_arready, s_bvalid, s_bresp, s_rvalid, m_valid} !== 7'b1110000) begin
            errors++;
            $display("FAIL midtx_reset_ctrl: got %b required 1110000",
                     {s_awready, s_wready, s_arready, s_bvalid, s_bresp, s_rvalid, m_valid});
        end
        checks++;
        if (s_rdata !== 32'h0) begin
            errors++;
            $display("FAIL midtx_reset_rdata: got %h required 00000000", s_rdata);
        end
        @(negedge aclk);
        aresetn = 1'b1;
        s_bready = 1'b1;
        axi_read(32'h4, rd, rv);
        checks++;
        if (rd !== 32'h0000_0001 || s_bvalid !== 1'b0) begin
            errors++;
            $display("FAIL midtx_after: got status %h bvalid %b required 00000001 0", rd, s_bvalid);
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_fill_drop();
        test_full_with_pop();
        test_aw_before_w();
        test_concurrent_rw();
        test_regmap();
        test_reset_midtx();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
